// File: rtl/isa_pkg.sv
// Shared ISA definitions: default widths, opcode constants, instruction field
// positions and the LM/SM walker state encoding.
package isa_pkg;

    localparam int ISA_DW     = 16;
    localparam int ISA_MASK_W = 8;
    localparam int ISA_RAW    = 3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADI = 4'd1;
    localparam logic [3:0] OP_NDU = 4'd2;
    localparam logic [3:0] OP_LHI = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd5;
    localparam logic [3:0] OP_LM  = 4'd6;
    localparam logic [3:0] OP_SM  = 4'd7;
    localparam logic [3:0] OP_JAL = 4'd8;
    localparam logic [3:0] OP_JLR = 4'd9;
    localparam logic [3:0] OP_BEQ = 4'd12;

    localparam int OPC_LSB  = 12;
    localparam int RA_LSB   = 9;
    localparam int RB_LSB   = 6;
    localparam int RC_LSB   = 3;
    localparam int CZ_LSB   = 0;
    localparam int IMM6_W   = 6;
    localparam int IMM9_W   = 9;
    localparam int MASK_LSB = 0;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WALK = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

    // Any opcode without a defined instruction is flagged illegal.
    function automatic logic is_illegal_op(input logic [3:0] op);
        logic ill;
        case (op)
            OP_ADD, OP_ADI, OP_NDU, OP_LHI,
            OP_LW,  OP_SW,  OP_LM,  OP_SM,
            OP_JAL, OP_JLR, OP_BEQ: ill = 1'b0;
            default:                ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/lsb_prio_enc8.sv
// Lowest-set-bit priority encoder for the 8-bit LM/SM register mask.
module lsb_prio_enc8 (
    input  logic [7:0] mask,
    output logic       any,
    output logic [2:0] idx
);

    // Bit 0 has highest priority so registers are walked R0 upward.
    always_comb begin
        any = |mask;
        casez (mask)
            8'b???????1: idx = 3'd0;
            8'b??????10: idx = 3'd1;
            8'b?????100: idx = 3'd2;
            8'b????1000: idx = 3'd3;
            8'b???10000: idx = 3'd4;
            8'b??100000: idx = 3'd5;
            8'b?1000000: idx = 3'd6;
            8'b10000000: idx = 3'd7;
            default:     idx = 3'd0;
        endcase
    end

endmodule

// File: rtl/instr_reg_decode.sv
// Instruction register with combinational field decode and the ascending
// LM/SM register-list walker used by the multicycle controller.
module instr_reg_decode
    import isa_pkg::*;
#(
    parameter int DW     = ISA_DW,
    parameter int MASK_W = ISA_MASK_W,
    parameter int RAW    = ISA_RAW
) (
    input  logic            clk,
    input  logic            proc_rst,
    input  logic [DW-1:0]   mem_dout,
    input  logic            wIR,
    input  logic            ms_start,
    input  logic            ms_step,
    output logic [DW-1:0]   IR,
    output logic [3:0]      opcode,
    output logic [RAW-1:0]  ra,
    output logic [RAW-1:0]  rb,
    output logic [RAW-1:0]  rc,
    output logic [1:0]      cz,
    output logic [DW-1:0]   imm6_sx,
    output logic [DW-1:0]   imm9_sx,
    output logic [DW-1:0]   lhi_imm,
    output logic            illegal,
    output logic [RAW-1:0]  ms_reg,
    output logic            ms_valid,
    output logic            ms_done,
    output logic [3:0]      ms_count
);

    logic [DW-1:0]     ir_r;
    ms_state_t         state_r;
    ms_state_t         state_nxt_s;
    logic [MASK_W-1:0] mask_r;
    logic [MASK_W-1:0] mask_nxt_s;
    logic [RAW-1:0]    reg_r;
    logic [3:0]        count_r;
    logic [3:0]        count_nxt_s;
    logic              enc_any_s;
    logic [RAW-1:0]    enc_idx_s;
    logic              walk_step_s;

    // Instruction register; write enable is active-low.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            ir_r <= '0;
        end else if (!wIR) begin
            ir_r <= mem_dout;
        end
    end

    assign IR      = ir_r;
    assign opcode  = ir_r[OPC_LSB +: 4];
    assign ra      = ir_r[RA_LSB +: RAW];
    assign rb      = ir_r[RB_LSB +: RAW];
    assign rc      = ir_r[RC_LSB +: RAW];
    assign cz      = ir_r[CZ_LSB +: 2];
    assign imm6_sx = {{(DW-IMM6_W){ir_r[IMM6_W-1]}}, ir_r[IMM6_W-1:0]};
    assign imm9_sx = {{(DW-IMM9_W){ir_r[IMM9_W-1]}}, ir_r[IMM9_W-1:0]};
    assign lhi_imm = {ir_r[IMM9_W-1:0], {(DW-IMM9_W){1'b0}}};
    assign illegal = is_illegal_op(ir_r[OPC_LSB +: 4]);

    // A start always wins over a step arriving in the same cycle.
    assign walk_step_s = (state_r == MS_WALK) && ms_step && !ms_start;

    // Mask and transfer-count update; reg_r always names the lowest bit left in mask_r.
    always_comb begin
        mask_nxt_s  = mask_r;
        count_nxt_s = count_r;
        if (ms_start) begin
            mask_nxt_s  = ir_r[MASK_LSB +: MASK_W];
            count_nxt_s = 4'd0;
        end else if (walk_step_s) begin
            mask_nxt_s  = mask_r & ~(8'd1 << reg_r);
            count_nxt_s = count_r + 4'd1;
        end else begin
            mask_nxt_s  = mask_r;
            count_nxt_s = count_r;
        end
    end

    lsb_prio_enc8 u_enc (
        .mask (mask_nxt_s),
        .any  (enc_any_s),
        .idx  (enc_idx_s)
    );

    // Walker state, mask, current index and count registers.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state_r <= MS_IDLE;
            mask_r  <= '0;
            reg_r   <= '0;
            count_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            mask_r  <= mask_nxt_s;
            reg_r   <= enc_idx_s;
            count_r <= count_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (ms_start) begin
            state_nxt_s = enc_any_s ? MS_WALK : MS_DONE;
        end else begin
            case (state_r)
                MS_IDLE: state_nxt_s = MS_IDLE;
                MS_WALK: begin
                    if (ms_step) begin
                        state_nxt_s = enc_any_s ? MS_WALK : MS_DONE;
                    end else begin
                        state_nxt_s = MS_WALK;
                    end
                end
                MS_DONE: state_nxt_s = MS_IDLE;
                default: state_nxt_s = MS_IDLE;
            endcase
        end
    end

    // Walker status outputs decoded from the state register.
    always_comb begin
        ms_valid = 1'b0;
        ms_done  = 1'b0;
        case (state_r)
            MS_IDLE: begin
                ms_valid = 1'b0;
                ms_done  = 1'b0;
            end
            MS_WALK: begin
                ms_valid = 1'b1;
                ms_done  = 1'b0;
            end
            MS_DONE: begin
                ms_valid = 1'b0;
                ms_done  = 1'b1;
            end
            default: begin
                ms_valid = 1'b0;
                ms_done  = 1'b0;
            end
        endcase
    end

    assign ms_reg   = reg_r;
    assign ms_count = count_r;

endmodule

// File: tb/tb_instr_reg_decode.sv
// Scoreboard bench for instr_reg_decode: stimulus queues expectations, a
// negedge monitor compares decode fields, walk indices and done counts.
module tb_instr_reg_decode;

    logic        clk = 1'b0;
    logic        proc_rst = 1'b0;
    logic [15:0] mem_dout = 16'h0000;
    logic        wir = 1'b1;
    logic        ms_start = 1'b0;
    logic        ms_step = 1'b0;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [2:0]  ra, rb, rc;
    logic [1:0]  cz;
    logic [15:0] imm6_sx, imm9_sx, lhi_imm;
    logic        illegal;
    logic [2:0]  ms_reg;
    logic        ms_valid, ms_done;
    logic [3:0]  ms_count;

    instr_reg_decode dut (
        .clk(clk), .proc_rst(proc_rst), .mem_dout(mem_dout), .wIR(wir),
        .ms_start(ms_start), .ms_step(ms_step), .IR(ir), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc), .cz(cz), .imm6_sx(imm6_sx), .imm9_sx(imm9_sx),
        .lhi_imm(lhi_imm), .illegal(illegal), .ms_reg(ms_reg), .ms_valid(ms_valid),
        .ms_done(ms_done), .ms_count(ms_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir, imm6, imm9, lhi;
        logic [3:0]  op;
        logic [2:0]  ra, rb, rc;
        logic [1:0]  cz;
        logic        ill;
    } dec_t;

    dec_t       dec_q[$];
    logic [2:0] reg_q[$];
    logic [3:0] cnt_q[$];
    dec_t       mon_e;
    int         total = 0;
    int         bad = 0;
    logic       load_seen = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=present required=absent", name);
    endtask

    always @(posedge clk) load_seen <= (wir == 1'b0) && proc_rst;

    always @(negedge clk) begin
        if (proc_rst) begin
            if (load_seen) begin
                if (dec_q.size() == 0) unexpected("dec_load");
                else begin
                    mon_e = dec_q.pop_front();
                    chk("ir",      ir,              mon_e.ir);
                    chk("opcode",  {12'd0, opcode}, {12'd0, mon_e.op});
                    chk("ra",      {13'd0, ra},     {13'd0, mon_e.ra});
                    chk("rb",      {13'd0, rb},     {13'd0, mon_e.rb});
                    chk("rc",      {13'd0, rc},     {13'd0, mon_e.rc});
                    chk("cz",      {14'd0, cz},     {14'd0, mon_e.cz});
                    chk("imm6_sx", imm6_sx,         mon_e.imm6);
                    chk("imm9_sx", imm9_sx,         mon_e.imm9);
                    chk("lhi_imm", lhi_imm,         mon_e.lhi);
                    chk("illegal", {15'd0, illegal}, {15'd0, mon_e.ill});
                end
            end
            if (ms_valid && !ms_start) begin
                if (reg_q.size() == 0) unexpected("ms_valid");
                else begin
                    chk("ms_reg", {13'd0, ms_reg}, {13'd0, reg_q[0]});
                    if (ms_step) void'(reg_q.pop_front());
                end
            end
            if (ms_done) begin
                if (cnt_q.size() == 0) unexpected("ms_done");
                else chk("ms_count_done", {12'd0, ms_count}, {12'd0, cnt_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] w, input logic [3:0] op,
                           input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                           input logic [1:0] z, input logic [15:0] i6, input logic [15:0] i9,
                           input logic [15:0] lh, input logic ill);
        dec_t e;
        e.ir = w; e.op = op; e.ra = a; e.rb = b; e.rc = c; e.cz = z;
        e.imm6 = i6; e.imm9 = i9; e.lhi = lh; e.ill = ill;
        dec_q.push_back(e);
        mem_dout = w;
        wir = 1'b0;
        tick();
        wir = 1'b1;
    endtask

    task automatic start_walk();
        ms_start = 1'b1;
        tick();
        ms_start = 1'b0;
    endtask

    task automatic steps(input int n, input int stall);
        for (int i = 0; i < n; i++) begin
            repeat (stall) tick();
            ms_step = 1'b1;
            tick();
            ms_step = 1'b0;
        end
    endtask

    task automatic push_regs(input logic [7:0] m);
        logic [7:0] mm;
        mm = m;
        for (int i = 0; i < 8; i++) if (mm[i]) reg_q.push_back(3'(i));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && (dec_q.size() + reg_q.size() + cnt_q.size()) != 0; i++) tick();
        total++;
        if ((dec_q.size() + reg_q.size() + cnt_q.size()) != 0) begin
            bad++;
            $display("FAIL drain_%s actual=dec%0d/reg%0d/cnt%0d pending required=none",
                     name, dec_q.size(), reg_q.size(), cnt_q.size());
            dec_q.delete(); reg_q.delete(); cnt_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        // Reset holds IR at zero even with a write strobe present.
        mem_dout = 16'h1234;
        wir = 1'b0;
        repeat (3) tick();
        chk("rst_ir",       ir,                  16'h0000);
        chk("rst_opcode",   {12'd0, opcode},     16'h0000);
        chk("rst_illegal",  {15'd0, illegal},    16'h0000);
        chk("rst_ms_reg",   {13'd0, ms_reg},     16'h0000);
        chk("rst_ms_valid", {15'd0, ms_valid},   16'h0000);
        chk("rst_ms_done",  {15'd0, ms_done},    16'h0000);
        chk("rst_ms_count", {12'd0, ms_count},   16'h0000);
        wir = 1'b1;
        proc_rst = 1'b1;
        tick();

        // Field decode for several opcodes, including illegal ones.
        load_ir(16'h1A7F, 4'd1,  3'd5, 3'd1, 3'd7, 2'd3, 16'hFFFF, 16'h007F, 16'h3F80, 1'b0);
        load_ir(16'h3F01, 4'd3,  3'd7, 3'd4, 3'd0, 2'd1, 16'h0001, 16'hFF01, 16'h8080, 1'b0);
        load_ir(16'hD5C3, 4'd13, 3'd2, 3'd7, 3'd0, 2'd3, 16'h0003, 16'hFFC3, 16'hE180, 1'b1);
        load_ir(16'hA000, 4'd10, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        load_ir(16'hC000, 4'd12, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        repeat (2) tick();
        chk("ir_hold", ir, 16'hC000);
        drain("decode");

        // Mask A5 stepped every cycle, then stray steps while idle.
        load_ir(16'h60A5, 4'd6, 3'd0, 3'd2, 3'd4, 2'd1, 16'hFFE5, 16'h00A5, 16'h5280, 1'b0);
        push_regs(8'hA5);
        cnt_q.push_back(4'd4);
        start_walk();
        steps(4, 0);
        drain("walk_a5");
        steps(2, 0);
        chk("idle_step_count", {12'd0, ms_count}, 16'h0004);
        chk("idle_step_valid", {15'd0, ms_valid}, 16'h0000);

        // Empty mask goes straight to done.
        load_ir(16'h6000, 4'd6, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        cnt_q.push_back(4'd0);
        start_walk();
        chk("empty_done_next", {15'd0, ms_done}, 16'h0001);
        drain("walk_empty");

        // Full mask with two-cycle stalls before each step.
        load_ir(16'h70FF, 4'd7, 3'd0, 3'd3, 3'd7, 2'd3, 16'hFFFF, 16'h00FF, 16'h7F80, 1'b0);
        push_regs(8'hFF);
        cnt_q.push_back(4'd8);
        start_walk();
        steps(8, 2);
        drain("walk_ff");

        // IR reload mid-walk leaves the walk alone; start+step restarts from new IR.
        push_regs(8'hFF);
        start_walk();
        steps(2, 0);
        load_ir(16'h60A5, 4'd6, 3'd0, 3'd2, 3'd4, 2'd1, 16'hFFE5, 16'h00A5, 16'h5280, 1'b0);
        reg_q.delete();
        cnt_q.delete();
        push_regs(8'hA5);
        cnt_q.push_back(4'd4);
        ms_start = 1'b1;
        ms_step = 1'b1;
        tick();
        ms_start = 1'b0;
        ms_step = 1'b0;
        steps(4, 0);
        drain("restart");

        // Reset mid-walk clears everything at once with no done pulse.
        load_ir(16'h600E, 4'd6, 3'd0, 3'd0, 3'd1, 2'd2, 16'h000E, 16'h000E, 16'h0700, 1'b0);
        push_regs(8'h0E);
        start_walk();
        steps(2, 0);
        #2;
        proc_rst = 1'b0;
        #1;
        chk("midrst_ir",       ir,                16'h0000);
        chk("midrst_ms_valid", {15'd0, ms_valid}, 16'h0000);
        chk("midrst_ms_done",  {15'd0, ms_done},  16'h0000);
        chk("midrst_ms_reg",   {13'd0, ms_reg},   16'h0000);
        chk("midrst_ms_count", {12'd0, ms_count}, 16'h0000);
        reg_q.delete();
        repeat (2) tick();
        proc_rst = 1'b1;
        repeat (4) tick();
        chk("post_rst_count", {12'd0, ms_count}, 16'h0000);
        drain("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
